systolic_output_collector: RTL and testbench

//  Downstream consumer of the systolic MAC array's macout bus. Result lanes

---
 rtl/systolic_output_collector.sv | 141 ++++++++++++++
 tb/tb_systolic_output_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_output_collector.sv
// Aligns skewed systolic MAC lanes into rows and buffers them in a FWFT FIFO; row visible ARRAY_SIZE cycles after mac_valid.
// Rows pushed into a full FIFO without a same-cycle pop are dropped (sticky overflow); macro RELU_EN clamps negative lanes to 0.
module systolic_output_collector #(
    parameter int ARRAY_SIZE = 9,
    parameter int DATA_SIZE  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TILE_ROWS  = 9
) (
    input  logic                             s_clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [DATA_SIZE*ARRAY_SIZE-1:0]  macout,
    input  logic                             mac_valid,
    output logic [DATA_SIZE*ARRAY_SIZE-1:0]  out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             overflow,
    output logic                             done
);

    localparam int RW  = DATA_SIZE * ARRAY_SIZE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int RCW = $clog2(TILE_ROWS + 1);

    logic [ARRAY_SIZE-2:0]  r_vpipe;
    logic [DATA_SIZE-1:0]   w_aligned [ARRAY_SIZE];
    logic [RW-1:0]          w_row;

    logic [RW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic [RCW-1:0]         r_row_cnt;
    logic                   r_done;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr;

    // Lane j arrives j cycles late, so it needs ARRAY_SIZE-1-j stages; the last lane feeds the FIFO directly.
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
        localparam int D = ARRAY_SIZE - 1 - j;
        if (D == 0) begin : g_direct
            assign w_aligned[j] = macout[DATA_SIZE*j +: DATA_SIZE];
        end else begin : g_dly
            logic [DATA_SIZE-1:0] r_sr [D];
            always_ff @(posedge s_clk or negedge reset) begin
                if (!reset) begin
                    for (int k = 0; k < D; k++) r_sr[k] <= '0;
                end else begin
                    r_sr[0] <= macout[DATA_SIZE*j +: DATA_SIZE];
                    for (int k = 1; k < D; k++) r_sr[k] <= r_sr[k-1];
                end
            end
            assign w_aligned[j] = r_sr[D-1];
        end
    end

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            r_vpipe <= '0;
        end else if (clear) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= mac_valid;
            for (int k = 1; k < ARRAY_SIZE - 1; k++) r_vpipe[k] <= r_vpipe[k-1];
        end
    end

    always_comb begin
        w_row = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
`ifdef RELU_EN
            w_row[DATA_SIZE*j +: DATA_SIZE] = w_aligned[j][DATA_SIZE-1] ? '0 : w_aligned[j];
`else
            w_row[DATA_SIZE*j +: DATA_SIZE] = w_aligned[j];
`endif
        end
    end

    assign w_push = r_vpipe[ARRAY_SIZE-2];
    assign w_pop  = (r_count != '0) && out_ready;
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge s_clk) begin
        if (w_wr && !clear) r_mem[r_wr_ptr] <= w_row;
    end

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge s_clk or negedge reset) begin
        if (!reset) begin
            r_row_cnt <= '0;
            r_done    <= 1'b0;
        end else if (clear) begin
            r_row_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                if (r_row_cnt == RCW'(TILE_ROWS - 1)) begin
                    r_row_cnt <= '0;
                    r_done    <= 1'b1;
                end else begin
                    r_row_cnt <= r_row_cnt + RCW'(1);
                end
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign done       = r_done;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector: a skew generator models the MAC array; inputs change on the falling edge.
module tb_systolic_output_collector;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int W  = N * DW;

    logic          s_clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          mac_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  macout = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    logic          sk_v [N];
    logic [W-1:0]  sk_r [N];

    typedef struct {
        logic [W-1:0] lanes;
        logic [W-1:0] exp_plain;
        logic [W-1:0] exp_relu;
    } vec_t;

    vec_t tbl [4];

    always #5 s_clk = ~s_clk;

    systolic_output_collector #(
        .ARRAY_SIZE(N), .DATA_SIZE(DW), .FIFO_DEPTH(4), .TILE_ROWS(9)
    ) dut (
        .s_clk(s_clk), .reset(reset), .clear(clear), .macout(macout),
        .mac_valid(mac_valid), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count), .overflow(overflow),
        .done(done)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mkrow(input int r);
        logic [W-1:0] row;
        row = '0;
        for (int j = 0; j < N; j++) row[DW*j +: DW] = 8'(r * 16 + j);
        return row;
    endfunction

    function automatic logic [W-1:0] exp_row(input int r);
        logic [W-1:0] row;
        row = mkrow(r);
`ifdef RELU_EN
        for (int j = 0; j < N; j++)
            if (row[DW*j + DW-1]) row[DW*j +: DW] = '0;
`endif
        return row;
    endfunction

    // Drive one cycle from a falling edge, then return at the next falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] row);
        for (int j = N - 1; j > 0; j--) begin
            sk_v[j] = sk_v[j-1];
            sk_r[j] = sk_r[j-1];
        end
        sk_v[0]   = v;
        sk_r[0]   = row;
        mac_valid = v;
        for (int j = 0; j < N; j++)
            macout[DW*j +: DW] = sk_v[j] ? sk_r[j][DW*j +: DW] : 8'hEE;
        @(negedge s_clk);
    endtask

    initial begin
        logic seen;
        for (int j = 0; j < N; j++) begin
            sk_v[j] = 1'b0;
            sk_r[j] = '0;
        end
        tbl[0] = '{72'h090807060504030201, 72'h090807060504030201, 72'h090807060504030201};
        tbl[1] = '{72'h807F807F807F807F80, 72'h807F807F807F807F80, 72'h007F007F007F007F00};
        tbl[2] = '{72'hFF0001FE7F80C33CAA, 72'hFF0001FE7F80C33CAA, 72'h000001007F00003C00};
        tbl[3] = '{72'h555555555555555555, 72'h555555555555555555, 72'h555555555555555555};

        // Reset held low for three cycles
        repeat (3) @(negedge s_clk);
        chk("rst_data", out_data, '0);
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_count", W'(fifo_count), '0);
        chk("rst_ovf", W'(overflow), '0);
        chk("rst_done", W'(done), '0);
        reset = 1'b1;
        out_ready = 1'b1;
        cycle(1'b0, '0);
        chk("post_rst_valid", W'(out_valid), '0);
        chk("post_rst_count", W'(fifo_count), '0);

        // Single rows: latency, alignment and optional clamp
        for (int t = 0; t < 4; t++) begin
            cycle(1'b1, tbl[t].lanes);
            repeat (7) cycle(1'b0, '0);
            chk($sformatf("tbl%0d_early", t), W'(out_valid), '0);
            cycle(1'b0, '0);
            chk($sformatf("tbl%0d_valid", t), W'(out_valid), 1);
            chk($sformatf("tbl%0d_count", t), W'(fifo_count), 1);
`ifdef RELU_EN
            chk($sformatf("tbl%0d_data", t), out_data, tbl[t].exp_relu);
`else
            chk($sformatf("tbl%0d_data", t), out_data, tbl[t].exp_plain);
`endif
            cycle(1'b0, '0);
            chk($sformatf("tbl%0d_gone", t), W'(out_valid), '0);
            chk($sformatf("tbl%0d_done", t), W'(done), '0);
        end

        // Nine back-to-back rows form one tile
        clear = 1'b1;
        cycle(1'b0, '0);
        clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(i < 9, mkrow(i));
            chk($sformatf("b2b%0d_valid", i), W'(out_valid), W'(i >= 8 && i <= 16));
            if (i >= 8 && i <= 16)
                chk($sformatf("b2b%0d_data", i), out_data, exp_row(i - 8));
            chk($sformatf("b2b%0d_done", i), W'(done), W'(i == 17));
        end

        // Overflow with consumer stalled
        clear = 1'b1;
        cycle(1'b0, '0);
        clear = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            cycle(i < 5, mkrow(i));
            if (i == 11) begin
                chk("ovf_count_pre", W'(fifo_count), 4);
                chk("ovf_flag_pre", W'(overflow), 0);
            end
            if (i == 12) begin
                chk("ovf_count", W'(fifo_count), 4);
                chk("ovf_flag", W'(overflow), 1);
                chk("ovf_head", out_data, exp_row(0));
            end
        end
        repeat (2) cycle(1'b0, '0);
        chk("stall_valid", W'(out_valid), 1);
        chk("stall_head", out_data, exp_row(0));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d", k), out_data, exp_row(k));
            cycle(1'b0, '0);
        end
        chk("drain_empty", W'(out_valid), 0);
        chk("ovf_sticky", W'(overflow), 1);
        clear = 1'b1;
        cycle(1'b0, '0);
        clear = 1'b0;
        chk("ovf_cleared", W'(overflow), 0);

        // Push into a full FIFO while popping
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            out_ready = (i == 12);
            cycle(i < 5, mkrow(i));
            if (i == 11) chk("full_count", W'(fifo_count), 4);
        end
        out_ready = 1'b0;
        chk("pp_count", W'(fifo_count), 4);
        chk("pp_ovf", W'(overflow), 0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("pp_drain%0d", k), out_data, exp_row(k));
            cycle(1'b0, '0);
        end
        chk("pp_empty", W'(out_valid), 0);

        // Clear discards in-flight rows and a same-cycle mac_valid
        cycle(1'b1, mkrow(5));
        repeat (2) cycle(1'b0, '0);
        clear = 1'b1;
        cycle(1'b1, mkrow(6));
        clear = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, '0);
            if (out_valid) seen = 1'b1;
        end
        chk("clr_inflight", W'(seen), 0);
        cycle(1'b1, mkrow(7));
        repeat (8) cycle(1'b0, '0);
        chk("after_clr_valid", W'(out_valid), 1);
        chk("after_clr_data", out_data, exp_row(7));
        cycle(1'b0, '0);

        // Async reset pulse with two rows buffered
        out_ready = 1'b0;
        cycle(1'b1, mkrow(1));
        cycle(1'b1, mkrow(2));
        repeat (9) cycle(1'b0, '0);
        chk("buf2_count", W'(fifo_count), 2);
        reset = 1'b0;
        #1;
        chk("arst_count", W'(fifo_count), 0);
        chk("arst_valid", W'(out_valid), 0);
        chk("arst_data", out_data, '0);
        #2;
        reset = 1'b1;
        @(negedge s_clk);
        chk("arst_hold", W'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
